// File: rtl/lmm_pkg.sv
// Shared types and constants for the large_matrix_mult compute tile.
// The optional LMM_SATURATE_EN macro (clamp instead of wrap) is consumed by lmm_dot.
package lmm_pkg;

    localparam int LMM_WIDTH        = 8;
    localparam int LMM_MATRIX_WIDTH = 4;
    localparam int LMM_ACC_W        = 2 * LMM_WIDTH + $clog2(LMM_MATRIX_WIDTH);
    localparam int LMM_CNT_W        = $clog2(LMM_MATRIX_WIDTH);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        OUTPUT  = 2'd3
    } lmm_state_e;

    typedef logic [LMM_MATRIX_WIDTH*LMM_WIDTH-1:0] lmm_row_t;

    function automatic logic [LMM_WIDTH-1:0] lmm_lane(input lmm_row_t row, input int unsigned k);
        return row[k*LMM_WIDTH +: LMM_WIDTH];
    endfunction

endpackage

// File: rtl/lmm_dot.sv
// Combinational dot product of one A row with one B column, reduced to one element.
// With LMM_SATURATE_EN defined the full-precision sum is clamped; otherwise it wraps.
import lmm_pkg::*;

module lmm_dot #(
    parameter int WIDTH        = LMM_WIDTH,
    parameter int MATRIX_WIDTH = LMM_MATRIX_WIDTH,
    parameter int ACC_W        = LMM_ACC_W
) (
    input  logic [MATRIX_WIDTH*WIDTH-1:0] a_row,
    input  logic [MATRIX_WIDTH*WIDTH-1:0] b_col,
    output logic [WIDTH-1:0]              c
);

    logic [ACC_W-1:0] acc_s;

    // Full-precision sum of lane-wise products
    always_comb begin
        acc_s = '0;
        for (int unsigned k = 0; k < MATRIX_WIDTH; k++) begin
            acc_s = acc_s + ACC_W'(lmm_lane(a_row, k)) * ACC_W'(lmm_lane(b_col, k));
        end
    end

`ifdef LMM_SATURATE_EN
    // Clamp to the largest representable element
    always_comb begin
        if (acc_s > ACC_W'({WIDTH{1'b1}})) begin
            c = '1;
        end else begin
            c = acc_s[WIDTH-1:0];
        end
    end
`else
    logic unused_acc_hi_s;
    assign unused_acc_hi_s = ^acc_s[ACC_W-1:WIDTH];

    // Wrap-around: keep only the low element bits
    always_comb begin
        c = acc_s[WIDTH-1:0];
    end
`endif

endmodule

// File: rtl/large_matrix_mult.sv
// Streaming C = A x B tile: row-wise load of A then B, one C row per cycle, row-wise drain.
// Define LMM_SATURATE_EN to clamp C elements instead of wrapping them.
import lmm_pkg::*;

module large_matrix_mult #(
    parameter int WIDTH        = LMM_WIDTH,
    parameter int NUM_ELEMENTS = LMM_MATRIX_WIDTH,
    parameter int MATRIX_WIDTH = LMM_MATRIX_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [NUM_ELEMENTS*WIDTH-1:0] Res,
    input  logic [NUM_ELEMENTS*WIDTH-1:0] wdata,
    input  logic                          write_en,
    input  logic                          read_en,
    output logic                          write_ready,
    output logic                          read_ready
);

    localparam int ROW_W = NUM_ELEMENTS * WIDTH;

    lmm_state_e                         state_q, state_d;
    logic [LMM_CNT_W-1:0]               cnt_q, cnt_d;
    logic [MATRIX_WIDTH-1:0][ROW_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;

    logic [ROW_W-1:0] b_col_s [MATRIX_WIDTH];
    logic [ROW_W-1:0] c_row_s;
    logic             adv_s;
    logic             last_s;

    assign last_s = (cnt_q == LMM_CNT_W'(MATRIX_WIDTH - 1));

    // Transpose B so each dot unit sees one column as a packed row
    always_comb begin
        for (int unsigned j = 0; j < MATRIX_WIDTH; j++) begin
            b_col_s[j] = '0;
            for (int unsigned k = 0; k < MATRIX_WIDTH; k++) begin
                b_col_s[j][k*WIDTH +: WIDTH] = lmm_lane(b_q[k], j);
            end
        end
    end

    for (genvar j = 0; j < MATRIX_WIDTH; j++) begin : g_col
        lmm_dot #(
            .WIDTH       (WIDTH),
            .MATRIX_WIDTH(MATRIX_WIDTH),
            .ACC_W       (LMM_ACC_W)
        ) u_dot (
            .a_row(a_q[cnt_q]),
            .b_col(b_col_s[j]),
            .c    (c_row_s[j*WIDTH +: WIDTH])
        );
    end

    // One shared row counter serves load, compute and drain since the phases never overlap
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        case (state_q)
            LOAD_A:  adv_s = write_en;
            LOAD_B:  adv_s = write_en;
            COMPUTE: adv_s = 1'b1;
            OUTPUT:  adv_s = read_en;
            default: adv_s = 1'b0;
        endcase

        if (adv_s) begin
            case (state_q)
                LOAD_A:  a_d[cnt_q] = wdata;
                LOAD_B:  b_d[cnt_q] = wdata;
                COMPUTE: c_d[cnt_q] = c_row_s;
                default: c_d = c_q;
            endcase
            if (last_s) begin
                cnt_d = '0;
                case (state_q)
                    LOAD_A:  state_d = LOAD_B;
                    LOAD_B:  state_d = COMPUTE;
                    COMPUTE: state_d = OUTPUT;
                    OUTPUT:  state_d = LOAD_A;
                    default: state_d = LOAD_A;
                endcase
            end else begin
                cnt_d = cnt_q + LMM_CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, counter and matrix storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

    // Handshake and output row decode
    always_comb begin
        write_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
        read_ready  = (state_q == OUTPUT);
        if (state_q == OUTPUT) begin
            Res = c_q[cnt_q];
        end else begin
            Res = '0;
        end
    end

endmodule

// File: tb/tb_large_matrix_mult.sv
// Randomised self-checking bench for large_matrix_mult against a plain-arithmetic matrix model.
module tb_large_matrix_mult;

    typedef logic [31:0] mat_t [4];

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Res;
    logic [31:0] wdata;
    logic        write_en;
    logic        read_en;
    logic        write_ready;
    logic        read_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    large_matrix_mult dut (
        .clk        (clk),
        .reset      (reset),
        .Res        (Res),
        .wdata      (wdata),
        .write_en   (write_en),
        .read_en    (read_en),
        .write_ready(write_ready),
        .read_ready (read_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Row i of A*B, element (i,j) = sum over k of A[i][k]*B[k][j]
    function automatic logic [31:0] ref_row(input mat_t a, input mat_t b, input int i);
        logic [31:0] r;
        int unsigned sum;
        int unsigned ea;
        int unsigned eb;
        int unsigned el;
        r = 32'h0;
        for (int j = 0; j < 4; j++) begin
            sum = 0;
            for (int k = 0; k < 4; k++) begin
                ea  = (a[i] >> (8 * k)) & 32'hFF;
                eb  = (b[k] >> (8 * j)) & 32'hFF;
                sum = sum + ea * eb;
            end
`ifdef LMM_SATURATE_EN
            el = (sum > 255) ? 255 : sum;
`else
            el = sum % 256;
`endif
            r = r | (el << (8 * j));
        end
        return r;
    endfunction

    task automatic run_matrix(input mat_t a, input mat_t b, input bit wstall, input bit rstall,
                              input string tag);
        mat_t exp;
        int   row;
        int   guard;
        int   n;
        int   r;
        for (int i = 0; i < 4; i++) exp[i] = ref_row(a, b, i);
        row   = 0;
        guard = 0;
        while (row < 8 && guard < 100) begin
            @(negedge clk);
            guard++;
            check({tag, "_load_wready"}, 32'(write_ready), 32'd1);
            write_en = !wstall || ($urandom_range(0, 1) == 1);
            wdata    = (row < 4) ? a[row] : b[row - 4];
            @(posedge clk);
            if (write_en) row++;
        end
        check({tag, "_rows_loaded"}, 32'(row), 32'd8);
        @(negedge clk);
        write_en = 1'b0;
        n = 0;
        while (!read_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd4);
        r     = 0;
        guard = 0;
        while (r < 4 && guard < 100) begin
            check({tag, "_rready"}, 32'(read_ready), 32'd1);
            check({tag, "_res"}, Res, exp[r]);
            read_en = !rstall || ($urandom_range(0, 1) == 1);
            @(posedge clk);
            if (read_en) r++;
            @(negedge clk);
            guard++;
        end
        read_en = 1'b0;
        check({tag, "_done_wready"}, 32'(write_ready), 32'd1);
        check({tag, "_done_rready"}, 32'(read_ready), 32'd0);
        check({tag, "_done_res"}, Res, 32'h0);
    endtask

    mat_t ident;
    mat_t bmat;
    mat_t ffm;
    mat_t ra;
    mat_t rb;
    bit   exp_rr;
    bit   exp_wr;

    initial begin
        ident = '{32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000};
        bmat  = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
        ffm   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

        // Reset held with write_en asserted
        reset    = 1'b0;
        write_en = 1'b1;
        read_en  = 1'b0;
        wdata    = $urandom;
        repeat (3) begin
            @(negedge clk);
            check("rst_res", Res, 32'h0);
            check("rst_wready", 32'(write_ready), 32'd1);
            check("rst_rready", 32'(read_ready), 32'd0);
        end

        // Constant ones with both enables held from reset release: exact cycle timeline
        wdata   = 32'h00000001;
        read_en = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            exp_rr = (cyc >= 12) && (cyc <= 15);
            exp_wr = (cyc <= 7) || (cyc >= 16);
            check($sformatf("ones_rready_c%0d", cyc), 32'(read_ready), 32'(exp_rr));
            check($sformatf("ones_wready_c%0d", cyc), 32'(write_ready), 32'(exp_wr));
            check($sformatf("ones_res_c%0d", cyc), Res, exp_rr ? 32'h00000001 : 32'h0);
        end
        write_en = 1'b0;
        read_en  = 1'b0;
        reset    = 1'b0;
        #1;
        check("ones_rst_wready", 32'(write_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;

        run_matrix(ident, bmat, 1'b0, 1'b0, "ident");
        run_matrix(ffm, ffm, 1'b0, 1'b0, "allff");
        run_matrix(ident, bmat, 1'b1, 1'b1, "ident_stall");

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 4; i++) begin
                ra[i] = $urandom;
                rb[i] = $urandom;
            end
            run_matrix(ra, rb, t[0], t[1], $sformatf("rand%0d", t));
        end

        // Reset after two B rows discards the partial load
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            write_en = 1'b1;
            wdata    = $urandom;
        end
        @(negedge clk);
        write_en = 1'b0;
        reset    = 1'b0;
        #1;
        check("midrst_wready", 32'(write_ready), 32'd1);
        check("midrst_rready", 32'(read_ready), 32'd0);
        check("midrst_res", Res, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        run_matrix(ident, bmat, 1'b0, 1'b0, "after_midrst");

        // Reset asserted while draining results
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            write_en = 1'b1;
            wdata    = $urandom;
        end
        @(negedge clk);
        write_en = 1'b0;
        repeat (4) @(negedge clk);
        check("outrst_pre_rready", 32'(read_ready), 32'd1);
        reset = 1'b0;
        #1;
        check("outrst_rready", 32'(read_ready), 32'd0);
        check("outrst_wready", 32'(write_ready), 32'd1);
        check("outrst_res", Res, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        run_matrix(ident, bmat, 1'b1, 1'b0, "after_outrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
